// File: rtl/systolic_4x4_if.sv
// systolic_4x4_if: tile request/result bundle between the tile controller and the systolic array.
interface systolic_4x4_if #(
    parameter int AW   = 8,
    parameter int BW   = 8,
    parameter int ACCW = 32
);
    logic                   start;
    logic signed [AW-1:0]   A_in  [0:3][0:3];
    logic signed [BW-1:0]   B_in  [0:3][0:3];
    logic                   done;
    logic signed [ACCW-1:0] C_out [0:3][0:3];
    modport master (output start, A_in, B_in, input done, C_out);
    modport slave  (input start, A_in, B_in, output done, C_out);
endinterface

// File: rtl/systolic_4x4.sv
// systolic_4x4: output-stationary 4x4 signed matrix multiplier, C = A x B, done 12 cycles after start.
// Define SYSTOLIC_SAT_EN to make every accumulate saturate instead of wrap.
module systolic_4x4_pe #(
    parameter int AW   = 8,
    parameter int BW   = 8,
    parameter int ACCW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [AW-1:0]   A_in,
    input  logic signed [BW-1:0]   B_in,
    output logic signed [AW-1:0]   A_out,
    output logic signed [BW-1:0]   B_out,
    output logic signed [ACCW-1:0] acc_out
);
    logic signed [AW-1:0]    r_a;
    logic signed [BW-1:0]    r_b;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [AW+BW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_x;
    logic signed [ACCW-1:0]  w_next;
    assign w_prod   = A_in * B_in;
    assign w_prod_x = ACCW'(w_prod);
`ifdef SYSTOLIC_SAT_EN
    logic [ACCW:0] w_sum;
    assign w_sum  = {r_acc[ACCW-1], r_acc} + {w_prod_x[ACCW-1], w_prod_x};
    // Disagreeing top two bits mean overflow; clamp toward the sign of the true sum.
    assign w_next = (w_sum[ACCW] != w_sum[ACCW-1]) ? {w_sum[ACCW], {(ACCW-1){~w_sum[ACCW]}}}
                                                   : w_sum[ACCW-1:0];
`else
    assign w_next = r_acc + w_prod_x;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_a   <= A_in;
            r_b   <= B_in;
            r_acc <= w_next;
        end
    end
    assign A_out   = r_a;
    assign B_out   = r_b;
    assign acc_out = r_acc;
endmodule

module systolic_4x4 #(
    parameter int AW   = 8,
    parameter int BW   = 8,
    parameter int ACCW = 32
) (
    input logic           clk,
    input logic           rst_n,
    systolic_4x4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                 r_state, w_next_state;
    logic [3:0]             r_t;
    logic                   r_done;
    logic signed [AW-1:0]   r_a_op [0:3][0:3];
    logic signed [BW-1:0]   r_b_op [0:3][0:3];
    logic signed [ACCW-1:0] r_c    [0:3][0:3];
    logic signed [AW-1:0]   w_a_inj [0:3];
    logic signed [BW-1:0]   w_b_inj [0:3];
    logic signed [AW-1:0]   w_a   [0:3][0:3];
    logic signed [BW-1:0]   w_b   [0:3][0:3];
    logic signed [ACCW-1:0] w_acc [0:3][0:3];
    logic                   w_clr, w_en;
    assign w_clr = (r_state == IDLE) && bus.start;
    assign w_en  = (r_state == RUN);
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = bus.start ? RUN : IDLE;
            RUN:     w_next_state = (r_t == 4'd10) ? DONE : RUN;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end
    // Skewed edge injection: row r / column c see element k exactly at step t = r+k / c+k.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_a_inj[r] = '0;
            w_b_inj[r] = '0;
            for (int k = 0; k < 4; k++) begin
                if (r_t == 4'(r + k)) begin
                    w_a_inj[r] = r_a_op[r][k];
                    w_b_inj[r] = r_b_op[k][r];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_done  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_a_op[r][c] <= '0;
                    r_b_op[r][c] <= '0;
                    r_c[r][c]    <= '0;
                end
            end
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == DONE);
            r_t     <= w_clr ? 4'd0 : (w_en ? r_t + 4'd1 : r_t);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (w_clr) begin
                        r_a_op[r][c] <= bus.A_in[r][c];
                        r_b_op[r][c] <= bus.B_in[r][c];
                    end
                    if (r_state == DONE) r_c[r][c] <= w_acc[r][c];
                end
            end
        end
    end
    // Step t=10 only moves zeros through the grid; it lets DONE land on the twelfth edge.
    for (genvar r = 0; r < 4; r++) begin : rows
        for (genvar c = 0; c < 4; c++) begin : cols
            logic signed [AW-1:0] w_a_left;
            logic signed [BW-1:0] w_b_top;
            if (c == 0) begin : g_a_edge
                assign w_a_left = w_a_inj[r];
            end else begin : g_a_pass
                assign w_a_left = w_a[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign w_b_top = w_b_inj[c];
            end else begin : g_b_pass
                assign w_b_top = w_b[r-1][c];
            end
            systolic_4x4_pe #(.AW(AW), .BW(BW), .ACCW(ACCW)) pe_i (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (w_clr),
                .en      (w_en),
                .A_in    (w_a_left),
                .B_in    (w_b_top),
                .A_out   (w_a[r][c]),
                .B_out   (w_b[r][c]),
                .acc_out (w_acc[r][c])
            );
        end
    end
    assign bus.done  = r_done;
    assign bus.C_out = r_c;
endmodule

// File: tb/tb_systolic_4x4.sv
// tb_systolic_4x4: directed tiles with hand-computed results for the 4x4 systolic array.
module tb_systolic_4x4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_4x4_if #(.AW(8), .BW(8), .ACCW(32)) bus ();
    systolic_4x4_if #(.AW(8), .BW(8), .ACCW(16)) bus16 ();

    systolic_4x4 #(.AW(8), .BW(8), .ACCW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    systolic_4x4 #(.AW(8), .BW(8), .ACCW(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    assign bus16.start = bus.start;
    assign bus16.A_in  = bus.A_in;
    assign bus16.B_in  = bus.B_in;

    int total = 0;
    int bad = 0;

    int ga [4][4] = '{'{1, 2, 3, 4}, '{0, -1, 2, 3}, '{2, 2, -1, 1}, '{4, 0, 1, -2}};
    int gb [4][4] = '{'{1, 0, -1, 2}, '{2, 1, 0, 0}, '{-1, 2, 1, 1}, '{3, -1, 2, 0}};
    int gc [4][4] = '{'{14, 4, 10, 5}, '{5, 0, 8, 2}, '{10, -1, -1, 3}, '{-3, 4, -7, 9}};
    int xa [4][4] = '{'{-128, 127, -1, 5}, '{33, -7, 0, 100}, '{-50, 64, -3, 2}, '{9, -99, 77, -128}};
    int id [4][4] = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    int zr [4][4];
    int mn [4][4];
    int big [4][4];

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a [4][4], input int b [4][4]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                bus.A_in[r][c] = 8'(a[r][c]);
                bus.B_in[r][c] = 8'(b[r][c]);
            end
    endtask

    task automatic start_tile();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_c(input string tag, input int e [4][4]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s_c%0d%0d", tag, r, c), bus.C_out[r][c], e[r][c]);
    endtask

    function automatic int dot(input int a [4][4], input int b [4][4], input int r, input int c);
        int s = 0;
        for (int k = 0; k < 4; k++) s += a[r][k] * b[k][c];
        return s;
    endfunction

    initial begin
        int n, ndone, first, held;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                zr[r][c]  = 0;
                mn[r][c]  = -128;
                big[r][c] = 65536;
            end
        bus.start = 1'b0;
        load(zr, zr);
        step();
        step();
        chk("rst_done", bus.done, 0);
        check_c("rst", zr);
        chk("rst_pe00_acc", dut.rows[0].cols[0].pe_i.acc_out, 0);
        rst_n = 1'b1;
        step();

        // golden tile
        load(ga, gb);
        start_tile();
        wait_done(20, n);
        chk("golden_lat", n, 12);
        check_c("golden", gc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("dot_c%0d%0d", r, c), bus.C_out[r][c], dot(ga, gb, r, c));
        chk("pe33_acc", dut.rows[3].cols[3].pe_i.acc_out, 9);
        chk("pe12_a_in_idle", dut.rows[1].cols[2].pe_i.A_in, 0);
        step();
        chk("done_fall", bus.done, 0);
        chk("golden_hold", bus.C_out[1][2], 8);

        // identity B
        load(xa, id);
        start_tile();
        wait_done(20, n);
        chk("ident_lat", n, 12);
        check_c("ident", xa);
        step();

        // extremes, also in the 16-bit accumulator instance
        load(mn, mn);
        start_tile();
        wait_done(20, n);
        chk("ext_lat", n, 12);
        check_c("ext", big);
        chk("ext16_done", bus16.done, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
`ifdef SYSTOLIC_SAT_EN
                chk($sformatf("ext16_c%0d%0d", r, c), bus16.C_out[r][c], 32767);
`else
                chk($sformatf("ext16_c%0d%0d", r, c), bus16.C_out[r][c], 0);
`endif
        step();

        // start while busy is ignored; input changes after E0 are not seen
        load(ga, gb);
        start_tile();
        step();
        step();
        load(xa, id);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ndone = 0;
        first = -1;
        for (int i = 4; i <= 30; i++) begin
            step();
            if (bus.done === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        chk("busy_ndone", ndone, 1);
        chk("busy_lat", first, 12);
        check_c("busy", gc);

        // reset in the middle of a run
        load(ga, gb);
        start_tile();
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("mrst_done", bus.done, 0);
        check_c("mrst", zr);
        step();
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            step();
            if (bus.done === 1'b1) ndone++;
        end
        chk("mrst_nodone", ndone, 0);
        chk("mrst_c33", bus.C_out[3][3], 0);
        load(xa, id);
        start_tile();
        wait_done(20, n);
        chk("mrst_relat", n, 12);
        check_c("mrst_rerun", xa);

        // back-to-back: next start at E13
        step();
        load(ga, gb);
        start_tile();
        wait_done(20, n);
        chk("b2b_lat1", n, 12);
        load(xa, id);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("b2b_done_fall", bus.done, 0);
        held = 0;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
            if (bus.C_out[0][0] == 14 && bus.C_out[3][3] == 9) held++;
        end
        chk("b2b_lat2", n, 12);
        chk("b2b_hold", held, 11);
        check_c("b2b", xa);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
